jump_target_resolver: RTL and testbench

JUMP_TARGET_RESOLVER -- requirements
Module: jump_target_resolver

---
 rtl/jr_fwd_pkg.sv | 23 ++
 rtl/jr_fwd_select.sv | 39 +++
 rtl/jump_target_resolver.sv | 118 +++++++++++
 tb/tb_jump_target_resolver.sv | 294 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/jr_fwd_pkg.sv
// Shared types and constants for the jump target resolver.
// Optional misalignment flag: define JR_MISALIGN_CHECK_EN.
package jr_fwd_pkg;

  localparam int JR_DATA_W  = 32;
  localparam int JR_ADDR_W  = 5;
  localparam int JR_NUM_FWD = 3;

  localparam logic [3:0] JR_WAIT_MAX = 4'd15;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_WAIT = 2'd1,
    ST_DONE = 2'd2
  } jr_state_e;

  function automatic logic [3:0] sat_inc(
    input logic [3:0] v
  );
    return (v == JR_WAIT_MAX) ? v : v + 4'd1;
  endfunction

endpackage

// File: rtl/jr_fwd_select.sv
// Priority forwarding select for the jump source register.
// Lowest channel index (youngest stage) wins; r0 never matches.
module jr_fwd_select
  import jr_fwd_pkg::*;
#(
  parameter int DATA_W  = JR_DATA_W,
  parameter int ADDR_W  = JR_ADDR_W,
  parameter int NUM_FWD = JR_NUM_FWD
) (
  input  logic [ADDR_W-1:0]         i_rs,
  input  logic [DATA_W-1:0]         i_reg_data,
  input  logic [NUM_FWD-1:0]        i_fwd_write,
  input  logic [NUM_FWD*ADDR_W-1:0] i_fwd_addr,
  input  logic [NUM_FWD-1:0]        i_fwd_ready,
  input  logic [NUM_FWD*DATA_W-1:0] i_fwd_data,
  output logic                      o_hit,
  output logic                      o_ready,
  output logic [DATA_W-1:0]         o_data
);

  logic w_rs_nz;
  assign w_rs_nz = |i_rs;

  // Walk oldest to youngest so the youngest match overwrites.
  always_comb begin
    o_hit   = 1'b0;
    o_ready = 1'b0;
    o_data  = i_reg_data;
    for (int k = NUM_FWD - 1; k >= 0; k--) begin
      if (i_fwd_write[k] && w_rs_nz &&
          i_fwd_addr[k*ADDR_W +: ADDR_W] == i_rs) begin
        o_hit   = 1'b1;
        o_ready = i_fwd_ready[k];
        o_data  = i_fwd_data[k*DATA_W +: DATA_W];
      end
    end
  end

endmodule

// File: rtl/jump_target_resolver.sv
// Resolves jr/jalr targets with forwarding and load-use stalls.
// Optional oMisaligned output: define JR_MISALIGN_CHECK_EN.
module jump_target_resolver
  import jr_fwd_pkg::*;
#(
  parameter int DATA_W  = JR_DATA_W,
  parameter int ADDR_W  = JR_ADDR_W,
  parameter int NUM_FWD = JR_NUM_FWD
) (
  input  logic                      iClk,
  input  logic                      iReset,
  input  logic                      iJrValid,
  input  logic [ADDR_W-1:0]         iJrRs,
  input  logic [DATA_W-1:0]         iIDRegReadData,
  input  logic                      iFlush,
  input  logic [NUM_FWD-1:0]        iFwdWrite,
  input  logic [NUM_FWD*ADDR_W-1:0] iFwdAddr,
  input  logic [NUM_FWD-1:0]        iFwdReady,
  input  logic [NUM_FWD*DATA_W-1:0] iFwdData,
  output logic                      oStall,
  output logic                      oTargetValid,
  output logic [DATA_W-1:0]         oJumpTarget,
  output logic [3:0]                oWaitCnt
`ifdef JR_MISALIGN_CHECK_EN
  ,
  output logic                      oMisaligned
`endif
);

  jr_state_e         r_state;
  logic              r_valid;
  logic [DATA_W-1:0] r_target;
  logic [3:0]        r_wait;

  logic              w_hit;
  logic              w_rdy;
  logic [DATA_W-1:0] w_src;
  logic              w_resolvable;
  logic              w_capture;

  jr_fwd_select #(
    .DATA_W  (DATA_W),
    .ADDR_W  (ADDR_W),
    .NUM_FWD (NUM_FWD)
  ) u_sel (
    .i_rs        (iJrRs),
    .i_reg_data  (iIDRegReadData),
    .i_fwd_write (iFwdWrite),
    .i_fwd_addr  (iFwdAddr),
    .i_fwd_ready (iFwdReady),
    .i_fwd_data  (iFwdData),
    .o_hit       (w_hit),
    .o_ready     (w_rdy),
    .o_data      (w_src)
  );

  assign w_resolvable = !w_hit || w_rdy;

  assign w_capture = !iFlush && w_resolvable &&
                     ((r_state == ST_IDLE && iJrValid) ||
                      r_state == ST_WAIT);

  assign oStall = iJrValid && (r_state != ST_DONE) && !iFlush;

  // oWaitCnt counts every cycle spent in WAIT, the capture cycle included.
  always_ff @(posedge iClk) begin
    if (iReset) begin
      r_state  <= ST_IDLE;
      r_valid  <= 1'b0;
      r_target <= '0;
      r_wait   <= '0;
    end else if (iFlush) begin
      r_state <= ST_IDLE;
      r_valid <= 1'b0;
      r_wait  <= '0;
    end else begin
      r_valid <= w_capture;
      if (w_capture) begin
        r_target <= w_src;
      end
      unique case (r_state)
        ST_IDLE: begin
          if (iJrValid) begin
            r_wait  <= '0;
            r_state <= w_resolvable ? ST_DONE : ST_WAIT;
          end
        end
        ST_WAIT: begin
          r_wait <= sat_inc(r_wait);
          if (w_resolvable) begin
            r_state <= ST_DONE;
          end
        end
        ST_DONE: r_state <= ST_IDLE;
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  assign oTargetValid = r_valid;
  assign oJumpTarget  = r_target;
  assign oWaitCnt     = r_wait;

`ifdef JR_MISALIGN_CHECK_EN
  logic r_misaligned;

  always_ff @(posedge iClk) begin
    if (iReset) begin
      r_misaligned <= 1'b0;
    end else if (w_capture && (|w_src[1:0])) begin
      r_misaligned <= 1'b1;
    end
  end

  assign oMisaligned = r_misaligned;
`endif

endmodule

// File: tb/tb_jump_target_resolver.sv
// Randomized bench for jump_target_resolver with a request-level model.
// Define JR_MISALIGN_CHECK_EN to also check oMisaligned.
module tb_jump_target_resolver;

  localparam int DW = 32;
  localparam int AW = 5;
  localparam int NF = 3;

  logic           iClk = 1'b0;
  logic           iReset;
  logic           iJrValid;
  logic [AW-1:0]  iJrRs;
  logic [DW-1:0]  iIDRegReadData;
  logic           iFlush;
  logic [NF-1:0]  iFwdWrite;
  logic [NF*AW-1:0] iFwdAddr;
  logic [NF-1:0]  iFwdReady;
  logic [NF*DW-1:0] iFwdData;
  logic           oStall;
  logic           oTargetValid;
  logic [DW-1:0]  oJumpTarget;
  logic [3:0]     oWaitCnt;
`ifdef JR_MISALIGN_CHECK_EN
  logic           oMisaligned;
`endif

  int n_cmp = 0;
  int n_bad = 0;

  logic [DW-1:0] exp_tgt = '0;
  logic          exp_mis = 1'b0;

  always #5 iClk = ~iClk;

  jump_target_resolver dut (
    .iClk           (iClk),
    .iReset         (iReset),
    .iJrValid       (iJrValid),
    .iJrRs          (iJrRs),
    .iIDRegReadData (iIDRegReadData),
    .iFlush         (iFlush),
    .iFwdWrite      (iFwdWrite),
    .iFwdAddr       (iFwdAddr),
    .iFwdReady      (iFwdReady),
    .iFwdData       (iFwdData),
    .oStall         (oStall),
    .oTargetValid   (oTargetValid),
    .oJumpTarget    (oJumpTarget),
    .oWaitCnt       (oWaitCnt)
`ifdef JR_MISALIGN_CHECK_EN
    ,
    .oMisaligned    (oMisaligned)
`endif
  );

  task automatic chk(input string tag,
                     input logic [31:0] got,
                     input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%08h expected 0x%08h",
               tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge iClk);
    #1;
  endtask

  task automatic fwd_clear();
    iFwdWrite = '0;
    iFwdAddr  = '0;
    iFwdReady = '0;
    iFwdData  = '0;
  endtask

  task automatic set_ch(input int k, input logic [AW-1:0] a,
                        input logic rdy, input logic [DW-1:0] d);
    iFwdWrite[k]          = 1'b1;
    iFwdAddr[k*AW +: AW]  = a;
    iFwdReady[k]          = rdy;
    iFwdData[k*DW +: DW]  = d;
  endtask

  // Spec rule: youngest matching channel decides; r0 never forwards.
  task automatic ref_eval(output bit res, output logic [DW-1:0] val);
    res = 1'b1;
    val = iIDRegReadData;
    for (int k = 0; k < NF; k++) begin
      if (iFwdWrite[k] && iJrRs != 0 &&
          iFwdAddr[k*AW +: AW] == iJrRs) begin
        res = iFwdReady[k];
        val = iFwdData[k*DW +: DW];
        return;
      end
    end
  endtask

  // Call one cycle after the capture edge, iJrValid still high.
  task automatic finish_chk(input string tag,
                            input logic [DW-1:0] val,
                            input int waits);
    int c;
    c = (waits > 15) ? 15 : waits;
    exp_tgt = val;
    if (val[1:0] != 2'b00) exp_mis = 1'b1;
    chk({tag, "_valid"}, 32'(oTargetValid), 32'd1);
    chk({tag, "_target"}, oJumpTarget, exp_tgt);
    chk({tag, "_waitcnt"}, 32'(oWaitCnt), 32'(c));
    chk({tag, "_stall_done"}, 32'(oStall), 32'd0);
`ifdef JR_MISALIGN_CHECK_EN
    chk({tag, "_mis"}, 32'(oMisaligned), 32'(exp_mis));
`endif
    iJrValid = 1'($urandom_range(0, 1));
    tick();
    iJrValid = 1'b0;
    chk({tag, "_pulse_end"}, 32'(oTargetValid), 32'd0);
    chk({tag, "_hold"}, oJumpTarget, exp_tgt);
  endtask

  task automatic rand_req();
    logic [AW-1:0] rs;
    int lim;
    int n;
    bit res;
    logic [DW-1:0] val;
    rs  = ($urandom_range(0, 5) == 0) ? '0 : AW'($urandom_range(1, 31));
    lim = $urandom_range(0, 20);
    n   = 0;
    iJrValid = 1'b1;
    iJrRs    = rs;
    forever begin
      iIDRegReadData = $urandom;
      for (int k = 0; k < NF; k++) begin
        iFwdWrite[k]         = 1'($urandom_range(0, 1));
        iFwdAddr[k*AW +: AW] = ($urandom_range(0, 1) == 1) ?
                               rs : AW'($urandom);
        iFwdReady[k]         = (n >= lim) ? 1'b1 :
                               ($urandom_range(0, 2) != 0);
        iFwdData[k*DW +: DW] = $urandom;
      end
      ref_eval(res, val);
      #1;
      chk("rnd_stall", 32'(oStall), 32'd1);
      chk("rnd_nopulse", 32'(oTargetValid), 32'd0);
      chk("rnd_keep", oJumpTarget, exp_tgt);
      tick();
      if (res) break;
      n++;
    end
    finish_chk("rnd", val, n);
    fwd_clear();
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

  initial begin
    iReset = 1'b1;
    iJrValid = 1'b0;
    iJrRs = '0;
    iIDRegReadData = '0;
    iFlush = 1'b0;
    fwd_clear();
    tick();
    tick();
    iReset = 1'b0;
    chk("rst_valid", 32'(oTargetValid), 32'd0);
    chk("rst_target", oJumpTarget, 32'd0);
    chk("rst_wait", 32'(oWaitCnt), 32'd0);
    chk("rst_stall", 32'(oStall), 32'd0);
    tick();

    // No forwarding match: register file value, single stall.
    iJrValid = 1'b1;
    iJrRs = 5'd8;
    iIDRegReadData = 32'h0040_0100;
    #1;
    chk("nomatch_stall", 32'(oStall), 32'd1);
    tick();
    finish_chk("nomatch", 32'h0040_0100, 0);

    // Two ready matches: youngest wins.
    set_ch(0, 5'd8, 1'b1, 32'hAAAA_0000);
    set_ch(2, 5'd8, 1'b1, 32'hBBBB_0000);
    iJrValid = 1'b1;
    #1;
    chk("prio_stall", 32'(oStall), 32'd1);
    tick();
    finish_chk("prio", 32'hAAAA_0000, 0);
    fwd_clear();

    // Load-use: ch0 not ready blocks even with ready older ch1.
    set_ch(0, 5'd8, 1'b0, 32'hDEAD_0000);
    set_ch(1, 5'd8, 1'b1, 32'hCAFE_0000);
    iJrValid = 1'b1;
    for (int c = 0; c < 2; c++) begin
      #1;
      chk("lu_stall", 32'(oStall), 32'd1);
      tick();
      chk("lu_nopulse", 32'(oTargetValid), 32'd0);
    end
    fwd_clear();
    set_ch(1, 5'd8, 1'b1, 32'h1234_5678);
    #1;
    chk("lu_stall", 32'(oStall), 32'd1);
    tick();
    finish_chk("lu", 32'h1234_5678, 2);
    fwd_clear();

    // Flush in WAIT with count at 3.
    set_ch(0, 5'd8, 1'b0, 32'h5555_0000);
    iJrValid = 1'b1;
    repeat (4) tick();
    chk("fl_wait3", 32'(oWaitCnt), 32'd3);
    iFlush = 1'b1;
    #1;
    chk("fl_stall", 32'(oStall), 32'd0);
    tick();
    iFlush = 1'b0;
    iJrValid = 1'b0;
    chk("fl_wait0", 32'(oWaitCnt), 32'd0);
    chk("fl_nopulse", 32'(oTargetValid), 32'd0);
    chk("fl_keep", oJumpTarget, exp_tgt);
    tick();
    chk("fl_nopulse2", 32'(oTargetValid), 32'd0);

    // r0 ignores a forwarding channel writing r0.
    fwd_clear();
    set_ch(0, 5'd0, 1'b0, 32'h0BAD_0000);
    iJrRs = 5'd0;
    iIDRegReadData = 32'h0040_0200;
    iJrValid = 1'b1;
    #1;
    chk("r0_stall", 32'(oStall), 32'd1);
    tick();
    finish_chk("r0", 32'h0040_0200, 0);
    fwd_clear();

`ifdef JR_MISALIGN_CHECK_EN
    iJrRs = 5'd9;
    iIDRegReadData = 32'h0040_0102;
    iJrValid = 1'b1;
    tick();
    finish_chk("mis_set", 32'h0040_0102, 0);
    iIDRegReadData = 32'h0040_0400;
    iJrValid = 1'b1;
    tick();
    finish_chk("mis_sticky", 32'h0040_0400, 0);
`endif

    repeat (40) rand_req();

    // Saturation, then reset beats flush and a pending request.
    iJrRs = 5'd8;
    set_ch(0, 5'd8, 1'b0, 32'h7777_0000);
    iJrValid = 1'b1;
    repeat (21) tick();
    chk("sat_wait", 32'(oWaitCnt), 32'd15);
    iReset = 1'b1;
    iFlush = 1'b1;
    tick();
    iReset = 1'b0;
    iFlush = 1'b0;
    iJrValid = 1'b0;
    fwd_clear();
    #1;
    exp_tgt = '0;
    exp_mis = 1'b0;
    chk("rst2_valid", 32'(oTargetValid), 32'd0);
    chk("rst2_target", oJumpTarget, exp_tgt);
    chk("rst2_wait", 32'(oWaitCnt), 32'd0);
    chk("rst2_stall", 32'(oStall), 32'd0);
`ifdef JR_MISALIGN_CHECK_EN
    chk("rst2_mis", 32'(oMisaligned), 32'(exp_mis));
`endif
    repeat (3) begin
      tick();
      chk("rst2_nopulse", 32'(oTargetValid), 32'd0);
    end

    repeat (20) rand_req();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_bad);
    $finish;
  end

endmodule
